fetch_unit: RTL and testbench

- Parametrised, decoupled instruction-fetch front end. Successor to the single-cycle core's pc / PC_MUX / inst_mem path.
- Owns the fetch PC and issues in-order requests to an instruction memory of variable latency. Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Consumed by fetch_unit and fetch_fifo; FETCH_BYPASS_EN is handled in fetch_unit.
package fetch_pkg;

  localparam int INST_W       = 32;
  localparam int INST_BYTES   = 4;
  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [INST_W-1:0]       inst;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; callers narrow to their XLEN.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous instruction queue; flush outranks push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  entry_t        push_entry,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output entry_t        head
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;
  entry_t        slots [DEPTH];

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = slots[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: credit-limited in-order requests,
// instruction queue, redirect flush. Define FETCH_BYPASS_EN for the zero-latency hit path.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW+1:0]   credit_used;
  logic            req_fire;
  logic            rsp_accept;
  logic            rsp_drop;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  entry_t          head;
  entry_t          push_entry;

  // Handshakes: a transfer happens on a cycle where valid && ready; once valid
  // is raised its payload is held until accepted (only a redirect withdraws it).
  assign redirect_aligned = XLEN'(align_pc(64'(redirect_pc)));
  assign credit_used      = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(discard);
  assign imem_req_valid   = rst && !redirect_valid && (credit_used < (CW+2)'(DEPTH));
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;

  assign rsp_drop   = imem_rsp_valid && (discard != '0);
  assign rsp_accept = imem_rsp_valid && (discard == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_accept && empty && inst_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push            = rsp_accept && !bypass;
  assign pop             = !empty && inst_ready && !redirect_valid;
  assign push_entry.inst = imem_rsp_data;
  assign push_entry.pc   = rsp_pc;

  assign inst_valid = !empty || bypass;
  assign inst       = bypass ? imem_rsp_data : (empty ? '0 : head.inst);
  assign inst_pc    = bypass ? rsp_pc        : (empty ? '0 : head.pc);

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .head       (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Every in-flight response becomes stale, including one landing now.
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      discard     <= discard + outstanding - CW'(imem_rsp_valid);
      outstanding <= '0;
    end else begin
      if (req_fire)   fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
      if (rsp_accept) rsp_pc   <= rsp_pc + XLEN'(INST_BYTES);
      if (rsp_drop)   discard  <= discard - CW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle model compare plus literal expectations.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;

  logic [63:0] exp_q[$];     // {inst, pc} the decode side must see, in order
  logic [32:0] fly_q[$];     // {stale, addr} of requests the memory still owes
  logic [31:0] m_pc;         // next address the fetcher must request
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  logic        last_rv;
  logic        last_iv;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h9C3A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (pop_log.size() > i) ? pop_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #2;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    exp_q.delete(); fly_q.delete(); mem_addr_q.delete(); mem_due_q.delete();
    req_log.delete(); pop_log.delete();
    m_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One clock cycle: memory drives its response, outputs are compared against
  // the model mid-cycle, then model and memory advance with the handshakes.
  task automatic cycle();
    logic        rsp_v;
    logic        exp_rv;
    logic        exp_iv;
    logic        byp;
    logic [63:0] exp_e;
    logic [32:0] f;
    rsp_v = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
    imem_rsp_valid = rsp_v;
    imem_rsp_data = rsp_v ? mem_data(mem_addr_q[0]) : 32'h0;
    #3;
    exp_rv = !redirect_valid && ((exp_q.size() + fly_q.size()) < DEPTH);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = rsp_v && (fly_q.size() > 0) && !fly_q[0][32] && (exp_q.size() == 0)
          && !redirect_valid && inst_ready;
`endif
    exp_iv = (exp_q.size() > 0) || byp;
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", inst_valid, exp_iv);
    if (exp_iv) begin
      exp_e = byp ? {mem_data(fly_q[0][31:0]), fly_q[0][31:0]} : exp_q[0];
      check("inst", inst, exp_e[63:32]);
      check("inst_pc", inst_pc, exp_e[31:0]);
    end
    last_rv = imem_req_valid;
    last_iv = inst_valid;
    last_addr = imem_req_addr;
    if (inst_valid && inst_ready && !redirect_valid) pop_log.push_back(inst_pc);
    if (imem_req_valid && imem_req_ready) begin
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(cyc + lat);
      req_log.push_back(imem_req_addr);
    end
    if (rsp_v) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (redirect_valid) begin
      if (rsp_v && fly_q.size() > 0) void'(fly_q.pop_front());
      foreach (fly_q[i]) fly_q[i][32] = 1'b1;
      exp_q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (exp_iv && inst_ready && !byp) void'(exp_q.pop_front());
      if (rsp_v && fly_q.size() > 0) begin
        f = fly_q.pop_front();
        if (!f[32] && !byp) exp_q.push_back({mem_data(f[31:0]), f[31:0]});
      end
      if (exp_rv && imem_req_ready) begin
        fly_q.push_back({1'b0, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int first_iv;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;

    // Streaming: latency 1, decode always ready.
    apply_reset();
    lat = 1;
    first_iv = -1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_iv && first_iv < 0) first_iv = k;
    end
    check("s1_req0", req_at(0), 32'h0);
    check("s1_req1", req_at(1), 32'h4);
    check("s1_req2", req_at(2), 32'h8);
    check("s1_nreq", req_log.size(), 10);
    check("s1_pop0", pop_at(0), 32'h0);
    check("s1_pop1", pop_at(1), 32'h4);
    check("s1_pop2", pop_at(2), 32'h8);
`ifdef FETCH_BYPASS_EN
    check("s1_first_valid", first_iv, 1);
    check("s1_npop", pop_log.size(), 9);
`else
    check("s1_first_valid", first_iv, 2);
    check("s1_npop", pop_log.size(), 8);
`endif

    // Decode stalled: credits cap outstanding + queued at DEPTH.
    apply_reset();
    lat = 2;
    inst_ready = 1'b0;
    run(10);
    check("s2_nreq", req_log.size(), 4);
    check("s2_req_valid_low", last_rv, 1'b0);
    check("s2_inst_valid", last_iv, 1'b1);
    inst_ready = 1'b1;
    req_log.delete();
    pop_log.delete();
    run(10);
    check("s2_pop0", pop_at(0), 32'h0);
    check("s2_pop1", pop_at(1), 32'h4);
    check("s2_pop2", pop_at(2), 32'h8);
    check("s2_pop3", pop_at(3), 32'hC);
    check("s2_pop4", pop_at(4), 32'h10);
    check("s2_resume_addr", req_at(0), 32'h10);

    // Memory back-pressure: request held stable.
    apply_reset();
    lat = 1;
    run(2);
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("s3_hold_valid", last_rv, 1'b1);
      check("s3_hold_addr", last_addr, 32'h8);
    end
    imem_req_ready = 1'b1;
    req_log.delete();
    run(3);
    check("s3_resume_addr", req_at(0), 32'h8);

    // Redirect with 0x8 and 0xC still in flight.
    apply_reset();
    lat = 1;
    run(2);
    lat = 4;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    lat = 1;
    cycle();
    redirect_valid = 1'b0;
    req_log.delete();
    pop_log.delete();
    run(7);
    check("s4_req0", req_at(0), 32'h100);
    check("s4_pop0", pop_at(0), 32'h100);
    check("s4_pop1", pop_at(1), 32'h104);

    // Redirect coincident with a response and a decode pop.
    apply_reset();
    lat = 2;
    run(4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    pop_log.delete();
    cycle();
    check("s5_flushed", last_iv, 1'b0);
    run(5);
    check("s5_pop0", pop_at(0), 32'h40);

    // Fetch PC wraps past the top of the address space.
    apply_reset();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF9;
    cycle();
    redirect_valid = 1'b0;
    req_log.delete();
    pop_log.delete();
    run(5);
    check("s6_req0", req_at(0), 32'hFFFF_FFF8);
    check("s6_req1", req_at(1), 32'hFFFF_FFFC);
    check("s6_req2", req_at(2), 32'h0);
    check("s6_pop0", pop_at(0), 32'hFFFF_FFF8);
    check("s6_pop1", pop_at(1), 32'hFFFF_FFFC);

    // Mixed traffic, then reset mid-operation.
    for (int k = 0; k < 150; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = 32'($urandom_range(0, 4095));
      lat = $urandom_range(1, 3);
      cycle();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    lat = 1;
    apply_reset();
    run(4);
    check("s7_req0", req_at(0), 32'h0);
    check("s7_pop0", pop_at(0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
